// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin result-bus arbiter between the rss and lsb completion queues
//   clk, rst (async, active low), rdy (global enable), reset_from_rob_bus (sync flush)
//   valid/ready/dest/value/next_pc_from_rss : ALU results into a 2-entry queue
//   valid/ready/dest/value_from_lsb         : load results into a 2-entry queue
//   dest/value/next_pc/src_to_bus           : registered one-cycle broadcast, dest 0 = idle
module cdb_arbiter #(
   parameter int ID_W   = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              reset_from_rob_bus,
   input  logic              valid_from_rss,
   output logic              ready_to_rss,
   input  logic [ID_W-1:0]   dest_from_rss,
   input  logic [DATA_W-1:0] value_from_rss,
   input  logic [DATA_W-1:0] next_pc_from_rss,
   input  logic              valid_from_lsb,
   output logic              ready_to_lsb,
   input  logic [ID_W-1:0]   dest_from_lsb,
   input  logic [DATA_W-1:0] value_from_lsb,
   output logic [ID_W-1:0]   dest_to_bus,
   output logic [DATA_W-1:0] value_to_bus,
   output logic [DATA_W-1:0] next_pc_to_bus,
   output logic              src_to_bus
);
   logic [ID_W-1:0]   r_dest_q [2];
   logic [DATA_W-1:0] r_val_q  [2];
   logic [DATA_W-1:0] r_pc_q   [2];
   logic [ID_W-1:0]   l_dest_q [2];
   logic [DATA_W-1:0] l_val_q  [2];
   logic [1:0]        r_cnt_q, r_cnt_d, l_cnt_q, l_cnt_d;
   logic              r_wp_q, r_wp_d, r_rp_q, r_rp_d;
   logic              l_wp_q, l_wp_d, l_rp_q, l_rp_d;
   logic              last_q, last_d;
   logic [ID_W-1:0]   dest_q, dest_d;
   logic [DATA_W-1:0] value_q, value_d, pc_q, pc_d;
   logic              src_q, src_d;
   logic              live, r_push, l_push, r_pop, l_pop, r_ne, l_ne;

   // Flush beats rdy; with either active no transfer or grant happens.
   assign live         = rdy && !reset_from_rob_bus;
   assign ready_to_rss = rdy && (r_cnt_q < 2'd2);
   assign ready_to_lsb = rdy && (l_cnt_q < 2'd2);
   // A dest-0 offer completes the handshake but is never stored.
   assign r_push = live && valid_from_rss && ready_to_rss && (dest_from_rss != '0);
   assign l_push = live && valid_from_lsb && ready_to_lsb && (dest_from_lsb != '0);
   assign r_ne   = r_cnt_q != 2'd0;
   assign l_ne   = l_cnt_q != 2'd0;
   // lsb wins only when alone or when rss was granted last.
   assign l_pop  = live && l_ne && (!r_ne || !last_q);
   assign r_pop  = live && r_ne && !l_pop;

   assign dest_to_bus    = dest_q;
   assign value_to_bus   = value_q;
   assign next_pc_to_bus = pc_q;
   assign src_to_bus     = src_q;

   always_comb begin
      r_cnt_d = reset_from_rob_bus ? 2'd0 : r_cnt_q + {1'b0, r_push} - {1'b0, r_pop};
      l_cnt_d = reset_from_rob_bus ? 2'd0 : l_cnt_q + {1'b0, l_push} - {1'b0, l_pop};
      r_wp_d  = reset_from_rob_bus ? 1'b0 : r_wp_q ^ r_push;
      r_rp_d  = reset_from_rob_bus ? 1'b0 : r_rp_q ^ r_pop;
      l_wp_d  = reset_from_rob_bus ? 1'b0 : l_wp_q ^ l_push;
      l_rp_d  = reset_from_rob_bus ? 1'b0 : l_rp_q ^ l_pop;
      last_d  = reset_from_rob_bus ? 1'b1 : (r_pop || l_pop) ? l_pop : last_q;
      dest_d  = r_pop ? r_dest_q[r_rp_q] : l_pop ? l_dest_q[l_rp_q] : '0;
      value_d = r_pop ? r_val_q[r_rp_q] : l_pop ? l_val_q[l_rp_q] : '0;
      pc_d    = r_pop ? r_pc_q[r_rp_q] : '0;
      src_d   = l_pop;
   end

   // Queue storage needs no reset: entries are only read while counted.
   always_ff @(posedge clk) begin
      if (r_push) begin
         r_dest_q[r_wp_q] <= dest_from_rss;
         r_val_q[r_wp_q]  <= value_from_rss;
         r_pc_q[r_wp_q]   <= next_pc_from_rss;
      end
      if (l_push) begin
         l_dest_q[l_wp_q] <= dest_from_lsb;
         l_val_q[l_wp_q]  <= value_from_lsb;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt_q <= 2'd0;
         l_cnt_q <= 2'd0;
         r_wp_q  <= 1'b0;
         r_rp_q  <= 1'b0;
         l_wp_q  <= 1'b0;
         l_rp_q  <= 1'b0;
         last_q  <= 1'b1;
         dest_q  <= '0;
         value_q <= '0;
         pc_q    <= '0;
         src_q   <= 1'b0;
      end else begin
         r_cnt_q <= r_cnt_d;
         l_cnt_q <= l_cnt_d;
         r_wp_q  <= r_wp_d;
         r_rp_q  <= r_rp_d;
         l_wp_q  <= l_wp_d;
         l_rp_q  <= l_rp_d;
         last_q  <= last_d;
         dest_q  <= dest_d;
         value_q <= value_d;
         pc_q    <= pc_d;
         src_q   <= src_d;
      end
   end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Result-bus arbiter between the execution units and the reorder buffer. The ALU reservation station (rss) and load/store buffer (lsb) each push completed results `{dest, value, next_pc}` into a private 2-entry queue. Each cycle, the arbiter picks one queued result by round-robin and broadcasts it on a single registered result bus. The reorder buffer and reservation stations sample that bus. A ROB flush discards everything in flight.

## Interface
- `ID_W`, default 4: ROB id width; id 0 means "no entry".
- `DATA_W`, default 32: value and pc width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset; asserted when 0.
- `rdy` in 1: global enable; state frozen when 0.
- `reset_from_rob_bus` in 1: synchronous flush.
- `valid_from_rss` in 1: rss result offered.
- `ready_to_rss` out 1: rss queue can accept.
- `dest_from_rss` in ID_W: ROB id.
- `value_from_rss` in DATA_W: result.
- `next_pc_from_rss` in DATA_W: resolved next pc.
- `valid_from_lsb` in 1: lsb result offered.
- `ready_to_lsb` out 1: lsb queue can accept.
- `dest_from_lsb` in ID_W: ROB id.
- `value_from_lsb` in DATA_W: loaded value.
- `dest_to_bus` out ID_W: broadcast ROB id; 0 = idle.
- `value_to_bus` out DATA_W: broadcast value.
- `next_pc_to_bus` out DATA_W: broadcast next pc; 0 for lsb results.
- `src_to_bus` out 1: 0 = rss, 1 = lsb.

## Operation
- **Queues:** two independent 2-entry circular FIFOs (rss, lsb). Each has a 1-bit rd/wr pointer and a 2-bit count (0..2). The lsb FIFO stores next_pc as 0.
- **Acceptance:**
  - `ready_to_X = rdy && count_X < 2`. Combinational on registered count only; it does not depend on same-cycle grant.
  - A transfer occurs at an edge where valid && ready.
  - A transfer with dest 0 is accepted and discarded (no write).
- **Arbitration:**
  - Register `last_grant` (0 = rss, 1 = lsb).
  - One queue non-empty: grant it.
  - Both non-empty: grant the one opposite `last_grant`.
  - On a grant, the head entry is popped and `last_grant` is updated.
  - Neither non-empty: no grant, `last_grant` unchanged.
- **Bus registers:**
  - On a grant: `dest/value/next_pc/src_to_bus <=` the popped entry.
  - No grant: `dest_to_bus <= 0`, and value, next_pc and src are also cleared to 0.
  - Every result therefore appears on the bus for exactly one cycle.
- **Same-edge push and pop:** allowed on a full queue only if ready was high, i.e. count < 2. Count arithmetic is `count + push − pop`, 2-bit, never wraps.
- **Flush (`reset_from_rob_bus` = 1 at an edge):**
  - Both counts and pointers go to 0.
  - Bus outputs go to 0.
  - `last_grant` goes to 1.
  - Any same-edge transfer is dropped.
  - Flush takes priority over `rdy`.
- **rdy = 0 at an edge (no flush):**
  - Queues, pointers and `last_grant` hold.
  - Bus outputs clear to 0.
  - No transfers occur, since ready is 0.
- **Reset (rst = 0):** asynchronous, with the same state as flush. It can be asserted mid-operation; queued results are lost.

## Timing
- **Reset values:**
  - `dest_to_bus`, `value_to_bus`, `next_pc_to_bus`, `src_to_bus` = 0.
  - `ready_to_rss` = `ready_to_lsb` = `rdy`.
  - `last_grant` = 1, so rss wins the first contention.
- **Latency:** a result transferred at edge k is visible on the bus after edge k+1 at the earliest. It is not visible in the cycle of transfer; there is no bypass.
- **Throughput:** one bus result per cycle.
- **Contention:** under continuous contention, grants alternate strictly. Maximum wait for a queue head is 1 extra cycle.
- **Back-pressure:** a requester pushing every cycle against a busy bus sees ready fall after 2 un-popped pushes.
- **Flush timing:** outputs are 0 in the cycle after the flush edge. Ready is high again in that same cycle (if rdy).

## Test plan
- **Reset and idle:**
  - Stimulus: rst=0, then 1 with no valids.
  - Required: all bus outputs 0, both readies 1, `dest_to_bus` stays 0 for 10 cycles.
- **Single rss result:**
  - Stimulus: dest=3, value=0x55, next_pc=0x1004 at edge k.
  - Required: after edge k+1, bus shows dest=3, value=0x55, next_pc=0x1004, src=0. After edge k+2, `dest_to_bus` = 0.
- **Contention round-robin:**
  - Stimulus: rss pushes dest 1, 2 and lsb pushes dest 5, 6 on the same two edges.
  - Required: bus sequence 1, 5, 2, 6 on consecutive cycles, with src 0, 1, 0, 1.
- **Back-pressure:**
  - Stimulus: `rdy` held so the bus is blocked (rdy=0 after two pushes); rss pushes dest 1, 2, then offers dest 3.
  - Required: `ready_to_rss` = 0 while count = 2. dest 3 is not accepted until after a pop. Output order is 1, 2, 3 with no loss or duplication.
- **Flush mid-stream:**
  - Stimulus: both queues hold 2 entries; `reset_from_rob_bus`=1 on the same edge as an rss push of dest 7.
  - Required: next cycle bus dest=0 and readies=1. No entry (including 7) ever appears afterward. The next contention grants rss first.
- **Async reset mid-operation and dest-0 drop:**
  - Stimulus: rst pulled low between edges with full queues.
  - Required: outputs go 0 immediately, without waiting for an edge.
  - Stimulus: push from lsb with dest=0.
  - Required: accepted (ready stays 1), and the bus never shows it.
